// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the synchronous FIFO: clog2 and
// elaboration-time parameter legality checks.
package sync_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit aw_ok(input int aw);
        return (aw >= 1) && (aw <= 10);
    endfunction

    function automatic bit af_ok(input int aw, input int af);
        return (af >= 1) && (af <= (1 << aw));
    endfunction

    function automatic bit ae_ok(input int aw, input int ae);
        return (ae >= 0) && (ae <= (1 << aw) - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x BW simple dual-port RAM: synchronous write, asynchronous read.
// Ports: i_clk, i_we/i_waddr/i_wdata write port, i_raddr/o_rdata read port.
import sync_fifo_pkg::*;

module fifo_mem #(
    parameter int BW = 8,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [BW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [BW-1:0] o_rdata
);

    localparam int DEPTH = 1 << AW;

    logic [BW-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with thresholds, sticky errors, FWFT/registered read.
// Ports: i_clk, i_rst_n (sync low), i_wr/i_data, i_rd, i_clr_err; o_data/o_valid, flags, o_fill.
import sync_fifo_pkg::*;

module sync_fifo #(
    parameter int BW     = 8,
    parameter int AW     = 4,
    parameter int AF_LVL = (1 << AW) - 2,
    parameter int AE_LVL = 2,
    parameter bit FWFT   = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr,
    input  logic [BW-1:0] i_data,
    input  logic          i_rd,
    input  logic          i_clr_err,
    output logic [BW-1:0] o_data,
    output logic          o_valid,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_afull,
    output logic          o_aempty,
    output logic [AW:0]   o_fill,
    output logic          o_overflow,
    output logic          o_underflow
);

    localparam int          DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_V   = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_V   = (AW+1)'(AE_LVL);

    if (!aw_ok(AW)) begin : g_bad_aw
        $error("sync_fifo: AW out of range 1..10");
    end
    if (!af_ok(AW, AF_LVL)) begin : g_bad_af
        $error("sync_fifo: AF_LVL out of range 1..DEPTH");
    end
    if (!ae_ok(AW, AE_LVL)) begin : g_bad_ae
        $error("sync_fifo: AE_LVL out of range 0..DEPTH-1");
    end

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   fill;
    logic          rd_ok;
    logic          wr_ok;
    logic [BW-1:0] rd_data;

    // Extra pointer bit disambiguates full from empty; subtraction wraps.
    assign fill     = wr_ptr - rd_ptr;
    assign o_fill   = fill;
    assign o_empty  = (fill == '0);
    assign o_full   = (fill == FULL_V);
    assign o_afull  = (fill >= AF_V);
    assign o_aempty = (fill <= AE_V);

    assign rd_ok = i_rd & ~o_empty;
    // A read in the same cycle frees the slot, so writing while full is legal.
    assign wr_ok = i_wr & (~o_full | rd_ok);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            // Set beats clear when both happen in one cycle.
            o_overflow  <= (i_wr & ~wr_ok) | (o_overflow & ~i_clr_err);
            o_underflow <= (i_rd & ~rd_ok) | (o_underflow & ~i_clr_err);
        end
    end

    fifo_mem #(
        .BW(BW),
        .AW(AW)
    ) u_mem (
        .i_clk  (i_clk),
        .i_we   (wr_ok),
        .i_waddr(wr_ptr[AW-1:0]),
        .i_wdata(i_data),
        .i_raddr(rd_ptr[AW-1:0]),
        .o_rdata(rd_data)
    );

    if (FWFT) begin : g_fwft
        assign o_data  = rd_data;
        assign o_valid = ~o_empty;
    end else begin : g_reg
        logic [BW-1:0] data_q;
        logic          valid_q;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_ok;
                if (rd_ok) data_q <= rd_data;
            end
        end

        assign o_data  = data_q;
        assign o_valid = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: FWFT and registered-read FIFOs driven in lockstep
// against a queue-based reference model, directed phases then random traffic.
module tb_sync_fifo;

    localparam int BW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_wr;
    logic [BW-1:0] i_data;
    logic          i_rd;
    logic          i_clr_err;

    logic [BW-1:0] d1, d0;
    logic          v1, v0;
    logic          full1, empty1, afull1, aempty1, ov1, un1;
    logic          full0, empty0, afull0, aempty0, ov0, un0;
    logic [AW:0]   fill1, fill0;

    sync_fifo #(.BW(BW), .AW(AW), .FWFT(1'b1)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_data(i_data),
        .i_rd(i_rd), .i_clr_err(i_clr_err), .o_data(d1), .o_valid(v1),
        .o_full(full1), .o_empty(empty1), .o_afull(afull1),
        .o_aempty(aempty1), .o_fill(fill1), .o_overflow(ov1),
        .o_underflow(un1)
    );

    sync_fifo #(.BW(BW), .AW(AW), .FWFT(1'b0)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr(i_wr), .i_data(i_data),
        .i_rd(i_rd), .i_clr_err(i_clr_err), .o_data(d0), .o_valid(v0),
        .o_full(full0), .o_empty(empty0), .o_afull(afull0),
        .o_aempty(aempty0), .o_fill(fill0), .o_overflow(ov0),
        .o_underflow(un0)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [BW-1:0] q[$];
    bit            m_ov, m_un;
    bit            m_v0;
    logic [BW-1:0] m_d0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit rst, input bit wr, input logic [BW-1:0] d,
                         input bit rd, input bit clr);
        bit            rok, wok;
        logic [BW-1:0] popped;
        if (!rst) begin
            q.delete();
            m_ov = 0;
            m_un = 0;
            m_v0 = 0;
            m_d0 = '0;
        end else begin
            rok = rd && (q.size() > 0);
            wok = wr && ((q.size() < DEPTH) || rok);
            popped = '0;
            if (rok) popped = q.pop_front();
            if (wok) q.push_back(d);
            m_ov = (wr && !wok) || (m_ov && !clr);
            m_un = (rd && !rok) || (m_un && !clr);
            m_v0 = rok;
            if (rok) m_d0 = popped;
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("fill",      32'(fill1),   32'(n));
        chk("fill_r",    32'(fill0),   32'(n));
        chk("empty",     32'(empty1),  32'(n == 0));
        chk("full",      32'(full1),   32'(n == DEPTH));
        chk("afull",     32'(afull1),  32'(n >= AF));
        chk("aempty",    32'(aempty1), 32'(n <= AE));
        chk("full_r",    32'(full0),   32'(n == DEPTH));
        chk("empty_r",   32'(empty0),  32'(n == 0));
        chk("afull_r",   32'(afull0),  32'(n >= AF));
        chk("aempty_r",  32'(aempty0), 32'(n <= AE));
        chk("overflow",  32'(ov1),     32'(m_ov));
        chk("underflow", 32'(un1),     32'(m_un));
        chk("ovf_r",     32'(ov0),     32'(m_ov));
        chk("unf_r",     32'(un0),     32'(m_un));
        chk("fwft_valid", 32'(v1),     32'(n > 0));
        if (n > 0) chk("fwft_data", 32'(d1), 32'(q[0]));
        chk("reg_valid", 32'(v0),      32'(m_v0));
        chk("reg_data",  32'(d0),      32'(m_d0));
    endtask

    task automatic step(input bit rst, input bit wr, input logic [BW-1:0] d,
                        input bit rd, input bit clr);
        i_rst_n   = rst;
        i_wr      = wr;
        i_data    = d;
        i_rd      = rd;
        i_clr_err = clr;
        @(posedge i_clk);
        model(rst, wr, d, rd, clr);
        #1;
        check_all();
    endtask

    initial begin
        i_rst_n = 0; i_wr = 0; i_data = '0; i_rd = 0; i_clr_err = 0;
        #1;

        // Reset held with write request asserted
        step(0, 1, 8'h55, 0, 0);
        step(0, 1, 8'h66, 0, 0);

        // Fill to full, then overflow
        for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(i), 0, 0);
        step(1, 1, 8'hEE, 0, 0);
        chk("ovf_17th", 32'(ov1), 32'd1);

        // Drain, then underflow
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'h00, 1, 0);
        step(1, 0, 8'h00, 1, 0);
        chk("unf_extra", 32'(un1), 32'd1);

        // Clear sticky flags
        step(1, 0, 8'h00, 0, 1);

        // Simultaneous read/write at full
        for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(8'h80 + i), 0, 0);
        step(1, 1, 8'hC3, 1, 0);
        chk("rw_full_fill", 32'(fill1), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) step(1, 0, 8'h00, 1, 0);

        // Read+write on empty: write only, underflow set
        step(1, 1, 8'h3C, 1, 0);
        step(1, 0, 8'h00, 1, 1);

        // Wrap: interleaved pairs at fill of about 3
        for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h40 + i), 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 1, 0);

        // Registered-read latency and FWFT visibility
        step(1, 1, 8'hA5, 0, 0);
        chk("fwft_a5", 32'(d1), 32'hA5);
        step(1, 0, 8'h00, 1, 0);
        chk("reg_a5", 32'(d0), 32'hA5);
        step(1, 0, 8'h00, 0, 0);
        chk("reg_v_drop", 32'(v0), 32'd0);

        // Overflow and clear in the same cycle: set wins
        for (int i = 0; i < DEPTH; i++) step(1, 1, 8'(i * 3), 0, 0);
        step(1, 1, 8'h99, 0, 1);
        chk("ovf_clr_same", 32'(ov1), 32'd1);
        step(1, 0, 8'h00, 0, 1);

        // Mid-operation reset at fill 7
        for (int i = 0; i < 9; i++) step(1, 0, 8'h00, 1, 0);
        step(0, 1, 8'h77, 1, 0);
        chk("rst_fill", 32'(fill1), 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 99) < 55),
                 8'($urandom),
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
